// File: rtl/bit_serializer_sar_pkg.sv
// Shared state encoding and sizing helper for the bit serializer.
// Parity support in the design is selected with the BIT_SER_PARITY_EN macro.
package bit_ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10,
    ST_GAP    = 2'b11
  } state_t;

  // Bits needed to hold WIDTH-1; never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bit_serializer_sar_shreg.sv
// Loadable shift register for the serializer: exposes the bit that will be on the line
// after this edge, plus the even parity of the loaded word (BIT_SER_PARITY_EN builds only).
module bit_ser_shreg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             bit_next,
  output logic             parity
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      data_d = MSB_FIRST ? {data_q[WIDTH-2:0], 1'b0} : {1'b0, data_q[WIDTH-1:1]};
    end
  end

  // Looking at data_d lets the top register the outgoing bit in the same edge as the shift.
  assign bit_next = MSB_FIRST ? data_d[WIDTH-1] : data_d[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

`ifdef BIT_SER_PARITY_EN
  logic parity_q, parity_d;

  // Parity is captured whole at load time because shifting destroys the word.
  always_comb begin
    parity_d = parity_q;
    if (load) parity_d = ^din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity = parity_q;
`else
  assign parity = 1'b0;
`endif

endmodule

// File: rtl/bit_serializer_sar.sv
// Parallel-to-serial front end for the sequence detector; all outputs registered.
// Define BIT_SER_PARITY_EN to append an even-parity bit to every word.
module bit_serializer_sar
  import bit_ser_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int            CW       = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
`ifdef BIT_SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gap_q, gap_d;
  logic          load, shift, word_end, xfer, last_d;
  logic          bit_next, parity;
  logic          din_ready_q, din_ready_d;
  logic          sout_q, sout_d;
  logic          sout_valid_q, sout_valid_d;
  logic          busy_q, busy_d;
  logic          word_done_q, word_done_d;

  assign xfer = din_valid & din_ready_q;

  bit_ser_shreg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .shift   (shift),
    .din     (din),
    .bit_next(bit_next),
    .parity  (parity)
  );

  // word_end marks the cycle carrying the final serial bit; its exit rule is shared.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    load     = 1'b0;
    shift    = 1'b0;
    word_end = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          load    = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          shift = 1'b1;
          cnt_d = cnt_q - 1'b1;
        end else if (PAR_EN) begin
          state_d = ST_PARITY;
        end else begin
          word_end = 1'b1;
        end
      end
      ST_PARITY: word_end = 1'b1;
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 4'd1;
      end
    endcase
    if (word_end) begin
      if (GAP > 0) begin
        state_d = ST_GAP;
        gap_d   = GAP_LOAD;
      end else if (xfer) begin
        load    = 1'b1;
        cnt_d   = CNT_LOAD;
        state_d = ST_SHIFT;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Outputs are decoded from the next state so every port comes straight off a flop.
  always_comb begin
    last_d       = PAR_EN ? (state_d == ST_PARITY) : ((state_d == ST_SHIFT) && (cnt_d == '0));
    sout_valid_d = (state_d == ST_SHIFT) || (state_d == ST_PARITY);
    busy_d       = (state_d != ST_IDLE);
    word_done_d  = last_d;
    din_ready_d  = (state_d == ST_IDLE) || ((GAP == 0) && last_d);
    case (state_d)
      ST_SHIFT:  sout_d = bit_next;
      ST_PARITY: sout_d = parity;
      default:   sout_d = IDLE_BIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      gap_q        <= '0;
      din_ready_q  <= 1'b0;
      sout_q       <= IDLE_BIT;
      sout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      din_ready_q  <= din_ready_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      busy_q       <= busy_d;
      word_done_q  <= word_done_d;
    end
  end

  assign din_ready  = din_ready_q;
  assign sout       = sout_q;
  assign sout_valid = sout_valid_q;
  assign busy       = busy_q;
  assign word_done  = word_done_q;

endmodule

// File: tb/tb_bit_serializer_sar.sv
// Bench for bit_serializer_sar: two instances (MSB-first no gap, LSB-first GAP=2 IDLE_BIT=1)
// checked every cycle against a per-cycle expectation queue, plus hand-computed streams.
module tb_bit_serializer_sar;

  typedef struct packed {
    logic sout;
    logic valid;
    logic busy;
    logic done;
  } ent_t;

`ifdef BIT_SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       dv [2];
  logic [7:0] dw [2];
  logic sout_a, sout_valid_a, din_ready_a, busy_a, word_done_a;
  logic sout_b, sout_valid_b, din_ready_b, busy_b, word_done_b;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  ent_t        mq [2][$];
  bit          fresh [2] = '{1'b1, 1'b1};
  bit          xfer  [2] = '{1'b0, 1'b0};
  int          p_msb [2] = '{1, 0};
  int          p_gap [2] = '{0, 2};
  logic        p_ib  [2] = '{1'b0, 1'b1};
  logic [31:0] cap   [2];
  int          ncap  [2];
  int          ndone [2];

  bit_serializer_sar #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(dw[0]), .din_valid(dv[0]), .din_ready(din_ready_a),
    .sout(sout_a), .sout_valid(sout_valid_a), .busy(busy_a), .word_done(word_done_a)
  );

  bit_serializer_sar #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(dw[1]), .din_valid(dv[1]), .din_ready(din_ready_b),
    .sout(sout_b), .sout_valid(sout_valid_b), .busy(busy_b), .word_done(word_done_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Ready whenever nothing is pending, or (no gap) while only the final serial bit remains.
  function automatic logic exp_ready(input int i);
    if (fresh[i]) return 1'b0;
    return (mq[i].size() == 0) || ((p_gap[i] == 0) && (mq[i].size() == 1));
  endfunction

  function automatic logic [4:0] exp_vec(input int i);
    ent_t e;
    if (mq[i].size() == 0) return {p_ib[i], 1'b0, exp_ready(i), 1'b0, 1'b0};
    e = mq[i][0];
    return {e.sout, e.valid, exp_ready(i), e.busy, e.done};
  endfunction

  task automatic push_word(input int i, input logic [7:0] w);
    ent_t e;
    for (int b = 0; b < 8; b++) begin
      e.sout  = (p_msb[i] != 0) ? w[7-b] : w[b];
      e.valid = 1'b1;
      e.busy  = 1'b1;
      e.done  = (b == 7) && (PB == 0);
      mq[i].push_back(e);
    end
    if (PB != 0) begin
      e.sout = ^w; e.valid = 1'b1; e.busy = 1'b1; e.done = 1'b1;
      mq[i].push_back(e);
    end
    for (int g = 0; g < p_gap[i]; g++) begin
      e.sout = p_ib[i]; e.valid = 1'b0; e.busy = 1'b1; e.done = 1'b0;
      mq[i].push_back(e);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mq[i].delete();
        fresh[i] = 1'b1;
        xfer[i]  = 1'b0;
      end else begin
        logic x;
        x = dv[i] && exp_ready(i);
        if (mq[i].size() != 0) void'(mq[i].pop_front());
        if (x) push_word(i, dw[i]);
        xfer[i]  = x;
        fresh[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [4:0] g;
    for (int i = 0; i < 2; i++) begin
      g = (i == 0) ? {sout_a, sout_valid_a, din_ready_a, busy_a, word_done_a}
                   : {sout_b, sout_valid_b, din_ready_b, busy_b, word_done_b};
      tests++;
      if (g !== exp_vec(i)) begin
        fails++;
        $display("[TB] FAIL cmp%0d cycle %0d: got %b required %b (sout,valid,ready,busy,done)",
                 i, cyc, g, exp_vec(i));
      end
      if (g[3] === 1'b1) begin
        cap[i] = {cap[i][30:0], g[4]};
        ncap[i]++;
      end
      if (g[0] === 1'b1) ndone[i]++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  task automatic clearCap(input int i);
    cap[i]   = '0;
    ncap[i]  = 0;
    ndone[i] = 0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Holds din_valid until the model reports acceptance, then scrambles din.
  task automatic applyStimulus(input int i, input logic [7:0] w);
    int n;
    n = 0;
    dw[i] = w;
    dv[i] = 1'b1;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!xfer[i] && n < 100);
    dv[i] = 1'b0;
    dw[i] = 8'($urandom);
    if (!xfer[i]) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept%0d: got no transfer required transfer of %0h", i, w);
    end
  endtask

  task automatic waitIdle(input int i);
    int n;
    n = 0;
    while (mq[i].size() != 0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (mq[i].size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL idle%0d: got %0d pending required 0", i, mq[i].size());
    end
  endtask

  initial begin
    int t0, t1;
    dv[0] = 1'b0; dv[1] = 1'b0;
    dw[0] = '0;   dw[1] = '0;
    clearCap(0);
    clearCap(1);
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_sout_a",  sout_a, 0);
    checkOutput("rst_valid_a", sout_valid_a, 0);
    checkOutput("rst_ready_a", din_ready_a, 0);
    checkOutput("rst_busy_a",  busy_a, 0);
    checkOutput("rst_done_a",  word_done_a, 0);
    checkOutput("rst_sout_b",  sout_b, 1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    checkOutput("ready_first_cycle", din_ready_a, 0);
    waitCycles(1);
    checkOutput("ready_after_release", din_ready_a, 1);

    // Single MSB-first word.
    clearCap(0);
    applyStimulus(0, 8'hA5);
    checkOutput("a5_first_bit", sout_a, 1);
    waitIdle(0);
    checkOutput("a5_stream", cap[0], (PB != 0) ? 32'h14A : 32'hA5);
    checkOutput("a5_bits",   ncap[0], 8 + PB);
    checkOutput("a5_done",   ndone[0], 1);
    checkOutput("a5_after_valid", sout_valid_a, 0);

    // Back-to-back words with din_valid held.
    clearCap(0);
    applyStimulus(0, 8'h55);
    t0 = cyc;
    applyStimulus(0, 8'hFF);
    t1 = cyc;
    checkOutput("b2b_spacing", t1 - t0, 8 + PB);
    waitIdle(0);
    checkOutput("b2b_stream", cap[0], (PB != 0) ? 32'h155FE : 32'h55FF);
    checkOutput("b2b_done",   ndone[0], 2);

    // Parity-sensitive words.
    clearCap(0);
    applyStimulus(0, 8'h07);
    waitIdle(0);
    checkOutput("w07_stream", cap[0], (PB != 0) ? 32'h0F : 32'h07);
    clearCap(0);
    applyStimulus(0, 8'h03);
    waitIdle(0);
    checkOutput("w03_stream", cap[0], (PB != 0) ? 32'h06 : 32'h03);

    // LSB-first with a two-cycle gap.
    clearCap(1);
    applyStimulus(1, 8'h01);
    checkOutput("lsb_first_bit", sout_b, 1);
    for (int c = 1; c <= 10 + PB; c++) begin
      waitCycles(1);
      if (c == 8 + PB) begin
        checkOutput("gap_valid", sout_valid_b, 0);
        checkOutput("gap_sout",  sout_b, 1);
        checkOutput("gap_ready", din_ready_b, 0);
        checkOutput("gap_busy",  busy_b, 1);
      end
      if (c == 9 + PB)  checkOutput("gap_ready_end", din_ready_b, 0);
      if (c == 10 + PB) checkOutput("ready_cycle11", din_ready_b, 1);
    end
    checkOutput("lsb01_stream", cap[1], (PB != 0) ? 32'h101 : 32'h80);
    clearCap(1);
    applyStimulus(1, 8'h96);
    waitIdle(1);
    checkOutput("lsb96_stream", cap[1], (PB != 0) ? 32'hD2 : 32'h69);

    // Reset mid-word.
    clearCap(0);
    applyStimulus(0, 8'hA5);
    waitCycles(3);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_sout",  sout_a, 0);
    checkOutput("abort_valid", sout_valid_a, 0);
    checkOutput("abort_done",  word_done_a, 0);
    checkOutput("abort_busy",  busy_a, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    checkOutput("abort_ready_low", din_ready_a, 0);
    waitCycles(1);
    checkOutput("abort_ready_high", din_ready_a, 1);
    checkOutput("abort_partial", cap[0], 32'h5);
    checkOutput("abort_no_done", ndone[0], 0);
    clearCap(0);
    applyStimulus(0, 8'h3C);
    waitIdle(0);
    checkOutput("w3c_stream", cap[0], (PB != 0) ? 32'h78 : 32'h3C);
    checkOutput("w3c_done",   ndone[0], 1);

    waitCycles(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_serializer_sar.md
# bit_serializer_sar

Parallel-to-serial front end for the sequence-detector chain. Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a single-bit stream that drives the detector's serial `in` input. Words go out MSB- or LSB-first, with configurable idle gaps between words. Sits directly upstream of the sequence detector FSM.

## Interface
- WIDTH, 8: data word width (2..32).
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- IDLE_BIT, 0: level driven on `sout` when no bit is valid.
- GAP, 0: idle cycles inserted after each word (0..15).
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word.
- din_valid  input  1  `din` holds a word.
- din_ready  output  1  block can accept; a transfer occurs on a rising edge with din_valid & din_ready.
- sout  output  1  serial bit to the detector's `in`.
- sout_valid  output  1  `sout` carries a data or parity bit this cycle.
- busy  output  1  a word is in flight: SHIFT, PARITY or GAP.
- word_done  output  1  one-cycle pulse in the cycle the final bit of a word is on `sout`.

## Operation
- States: IDLE, SHIFT, PARITY (parity build only), GAP.
- IDLE: din_ready=1, sout=IDLE_BIT, sout_valid=0. A transfer loads the shift register, sets bit counter to WIDTH-1 and moves to SHIFT.
- SHIFT: sout = current bit, sout_valid=1. Counter decrements each cycle. At count 0 the next state is:
  - PARITY, when parity is compiled in;
  - otherwise GAP, when GAP>0;
  - otherwise IDLE, or SHIFT again if a transfer occurs that cycle.
- PARITY: one cycle, sout = even parity (XOR of the word), sout_valid=1. Exit follows the same GAP/IDLE/back-to-back rule.
- GAP: GAP cycles at sout=IDLE_BIT, sout_valid=0, din_ready=0. Then IDLE.
- Back-to-back: when GAP==0, din_ready is also 1 during the final bit cycle. A transfer there starts the next word with no bubble.
- din_ready is 0 in all other SHIFT/PARITY/GAP cycles. din_valid held while ready=0 is ignored; the word is not lost, it is accepted once ready rises.
- busy=1 in SHIFT, PARITY and GAP.

## Timing
- All outputs are registered.
- Reset values: sout=IDLE_BIT, sout_valid=0, din_ready=0, busy=0, word_done=0, state IDLE. din_ready rises on the first rising edge after rst_n deasserts.
- Latency: word accepted at edge k → first bit on sout in cycle k+1 → last data bit in cycle k+WIDTH (k+WIDTH+1 with parity).
- word_done is high in the same cycle as the last bit.
- Throughput with GAP=0: one bit every cycle, sustained.
- Reset asserted mid-word aborts immediately (asynchronous): sout=IDLE_BIT, sout_valid=0, no word_done, partial word discarded.
- din is sampled only on the transfer edge; later changes have no effect.

## Configuration
- BIT_SER_PARITY_EN defined: PARITY state present; each word is WIDTH+1 serial bits, the last being even parity.
- BIT_SER_PARITY_EN undefined: no PARITY state; each word is WIDTH bits; parity logic is absent.

## Structure
- Package bit_ser_pkg:
  - state typedef (IDLE/SHIFT/PARITY/GAP) with fixed 2-bit encoding 00/01/10/11;
  - counter-width function clog2(WIDTH).
- One sub-module, bit_ser_shreg: loadable shift register with direction from MSB_FIRST, exposing the current output bit and parallel parity.
- FSM, counters and handshake stay in the top module.

## Test plan
- WIDTH=8, MSB_FIRST=1, din=0xA5 accepted at edge 0 → sout=1,0,1,0,0,1,0,1 in cycles 1..8, sout_valid=1 throughout, word_done only in cycle 8, then sout=0, sout_valid=0.
- GAP=0, din_valid held with 0x55 then 0xFF → din_ready high in cycle 8; 16 contiguous valid bits 0101010111111111; word_done in cycles 8 and 16.
- MSB_FIRST=0, GAP=2, din=0x01 → sout=1,0,0,0,0,0,0,0; then two cycles of sout_valid=0 with din_ready=0; din_ready=1 in cycle 11.
- BIT_SER_PARITY_EN, din=0x07 → 8 data bits, then parity bit 1 in cycle 9; word_done in cycle 9. din=0x03 → parity bit 0.
- rst_n pulled low in cycle 4 of 0xA5 → sout=IDLE_BIT and sout_valid=0 immediately; no word_done. After release, din_ready=1 on the next edge; a new word 0x3C serializes correctly.
- Chained with the sequence detector, stream of 0x55 → detector `out` matches its standalone response to serial input 0,1,0,1,0,1,0,1.
